// File: rtl/btn_sum_accum.sv
// btn_sum_accum: three debounced push-buttons driving a 9-bit add/accumulate
// register with a sticky overflow flag.
// Optional build macro: SUM_SATURATE_EN -- accumulate overflow clamps sum to
// 511 instead of wrapping (ovf is set either way).

// Per-button lane: 2-flop synchroniser, tick-sampled debouncer, rising-edge pulse.
module btn_sum_db #(
  parameter int DB_SAMPLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  // Accept a new level only after DB_SAMPLES consecutive disagreeing ticks;
  // any agreeing tick restarts the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (tick) begin
      if (sync[1] != level) begin
        if (cnt == CW'(DB_SAMPLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Delayed level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;
endmodule

module btn_sum_accum #(
  parameter int TICK_DIV   = 100_000,
  parameter int DB_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_add,
  input  logic       btn_acc,
  input  logic       btn_clr,
  input  logic [7:0] sw_a,
  input  logic [7:0] sw_b,
  output logic [8:0] sum,
  output logic       sum_upd,
  output logic       ovf
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Button lane indices.
  localparam int B_ADD = 0;
  localparam int B_ACC = 1;
  localparam int B_CLR = 2;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_ACC, OP_CLR} op_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [2:0]    raw, level, cmd;
  state_t        state;
  op_t           op;
  logic [9:0]    acc_t;
  logic [8:0]    acc_ovf_val;

  // Free-running sample-tick divider.
  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));
  assign raw  = {btn_clr, btn_acc, btn_add};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_sum_db #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw[i]),
      .level (level[i]),
      .rise  (cmd[i])
    );
  end

  assign acc_t = {1'b0, sum} + {2'b00, sw_a};
`ifdef SUM_SATURATE_EN
  assign acc_ovf_val = 9'd511;
`else
  assign acc_ovf_val = acc_t[8:0];
`endif

  // Command FSM: latch one command, execute it for a single cycle, then wait
  // until every button is released so a held button cannot re-trigger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      op      <= OP_ADD;
      sum     <= '0;
      sum_upd <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      sum_upd <= 1'b0;
      case (state)
        IDLE: if (|cmd) begin
          state <= EXEC;
          op    <= cmd[B_CLR] ? OP_CLR : (cmd[B_ADD] ? OP_ADD : OP_ACC);
        end
        EXEC: begin
          sum_upd <= 1'b1;
          state   <= HOLD;
          case (op)
            OP_ADD: sum <= {1'b0, sw_a} + {1'b0, sw_b};
            OP_ACC: begin
              if (acc_t[9]) begin
                ovf <= 1'b1;
                sum <= acc_ovf_val;
              end else begin
                sum <= acc_t[8:0];
              end
            end
            default: begin
              sum <= '0;
              ovf <= 1'b0;
            end
          endcase
        end
        HOLD: if (~|level) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/btn_sum_accum.md
BTN_SUM_ACCUM -- requirements
Module: btn_sum_accum

Interface
REQ-001 Parameter TICK_DIV, default 100_000, meaning: clk cycles per debounce sample tick.
REQ-002 Parameter DB_SAMPLES, default 8, meaning: consecutive equal samples needed to accept a button level change.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 btn_add  input  1  raw push-button: load sw_a + sw_b.
REQ-006 btn_acc  input  1  raw push-button: accumulate sum + sw_a.
REQ-007 btn_clr  input  1  raw push-button: clear sum and ovf.
REQ-008 sw_a  input  8  operand A, unsigned, from slide switches.
REQ-009 sw_b  input  8  operand B, unsigned, from slide switches.
REQ-010 sum  output  9  registered result, drives the 7-segment display controller input directly.
REQ-011 sum_upd  output  1  one-cycle pulse on the cycle sum takes a new value.
REQ-012 ovf  output  1  sticky accumulate-overflow flag.

Function
REQ-013 Tick generator: counter 0..TICK_DIV-1, wraps; tick is high for one cycle at terminal count.
REQ-014 Debounce per button: on tick, a 2-flop-synchronised raw level is sampled; the debounced level changes only after DB_SAMPLES consecutive ticks disagree with it; any agreeing sample restarts the count.
REQ-015 Edge detect: a rising edge of the debounced level gives a one-cycle cmd pulse; falling edges give nothing.
REQ-016 FSM states: IDLE, EXEC, HOLD.
REQ-017 IDLE -> EXEC on any cmd pulse; the command is latched that cycle with priority clr > add > acc.
REQ-018 EXEC (exactly one cycle): sum is updated, sum_upd = 1, -> HOLD.
REQ-019 HOLD -> IDLE only when all three debounced levels are 0; cmd pulses arriving in EXEC or HOLD are dropped.
REQ-020 Latency: cmd pulse at edge N, sum and sum_upd valid after edge N+2.
REQ-021 add: sum = {1'b0,sw_a} + {1'b0,sw_b}, max 510, never overflows; ovf is unchanged.
REQ-022 acc: 10-bit t = sum + sw_a; if t > 511, ovf is set to 1 and sum follows REQ-026; otherwise sum = t[8:0].
REQ-023 clr: sum = 0, ovf = 0, sum_upd = 1.
REQ-024 Operands are sampled in the EXEC cycle, not at the button press.

Reset
REQ-025 reset = 0 at a clk edge forces: FSM IDLE; sum 0; sum_upd 0; ovf 0; tick counter 0; debounced levels, synchronisers and sample counters 0. Reset mid-EXEC or mid-HOLD aborts the operation with no sum_upd.

Configuration
REQ-026 Macro SUM_SATURATE_EN: when defined, acc overflow sets sum to 511; when undefined, acc overflow wraps, sum = t[8:0]. ovf is set in both cases.

Verification
REQ-027 Bench uses TICK_DIV = 4 and DB_SAMPLES = 3. Cases:
- reset low 3 cycles, then high -> sum = 0, ovf = 0, sum_upd = 0.
- sw_a = 200, sw_b = 55, press btn_add stable for 20 ticks -> exactly one sum_upd pulse, sum = 255.
- btn_add bouncing every 2 clk for 30 clk, then stable high -> a single sum_upd pulse, none during the bounce.
- sum = 500, sw_a = 20, press acc -> ovf = 1; sum = 511 with the macro defined, sum = 8 without it.
- btn_clr and btn_add debounced on the same cycle -> sum = 0, ovf = 0.
- hold btn_add, press btn_acc during HOLD -> no second update until all buttons are released and pressed again.
